fifo_channel_module: RTL and testbench
======================================

Name: fifo_channel_module

Overview:
- Bounded FIFO channel implementing one KPN edge.
- Sits directly upstream of subtractor_module: it buffers 16-bit tokens from a producer process and delivers them on the consumer's rd strobe, which then drive entry_1 / entry_2.
- One instance per operand edge.
- Blocking-write/blocking-read semantics are exposed as full/empty so processes can stall.

Parameters:
- DATA_WIDTH, 16, token width in bits. Matches the subtractor operand width.
- DEPTH, 8, number of token slots. Must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width. Derived; never overridden.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- wr  input  1  producer write strobe; sampled at posedge clk.
- data_in  input  DATA_WIDTH  token written when wr is accepted.
- rd  input  1  consumer read strobe; sampled at posedge clk.
- data_out  output  DATA_WIDTH  registered token from the last accepted read.
- data_valid  output  1  high for exactly the cycle after an accepted read.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a rejected write.
- underflow  output  1  sticky; set by a rejected read.

Behaviour:
- Reset (asynchronous assert, synchronous release on the next posedge after reset_n goes high):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, data_valid = 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
  - Storage contents are don't-care.
- Reset mid-operation discards all stored tokens immediately; there is no partial drain.
- Accept rules, evaluated on the state before the edge:
  - wr_acc = wr && (!full || rd_acc).
  - rd_acc = rd && !empty.
- Write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap via ADDR_WIDTH bits).
- Read: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; data_valid <= 1. data_valid <= 0 on any cycle without rd_acc.
- data_out holds its last value when no read is accepted.
- Read latency is 1 cycle: the token appears on data_out with data_valid at the edge following the rd sample.
- count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged on both or neither.
- full and empty are combinational decodes of the registered count, so there are no glitches from ptr compare.
- Simultaneous wr and rd:
  - Non-empty, non-full: both occur; count unchanged.
  - Full: both occur. The read returns the oldest token, the write fills the freed slot, and full stays 1.
  - Empty: read rejected (underflow set), write accepted; count becomes 1. No fall-through: the written token is readable from the next cycle.
- Rejected write (wr && full && !rd_acc): data dropped, overflow <= 1, no state change otherwise.
- Rejected read (rd && empty): underflow <= 1, data_out unchanged, data_valid = 0.
- overflow and underflow clear only on reset.
- Tokens are delivered strictly in write order (Kahn determinism). No token may be duplicated or lost except a flagged overflow.

Decomposition:
- Shared package kpn_pkg holds:
  - KPN_DATA_WIDTH = 16.
  - typedef logic [KPN_DATA_WIDTH-1:0] kpn_token_t.
  - KPN_DEFAULT_DEPTH = 8.
- One sub-module, fifo_storage_ram: DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous read port. It has no reset on the array.
- Pointer, count and flag logic stay in fifo_channel_module.

Test Plan (DEPTH=4):
- Reset then idle: reset_n low 2 cycles, release → empty=1, full=0, count=0, data_out=0x0000, overflow=0, underflow=0.
- Fill and drain: write 0x0005, 0x0003, 0x7FFF, 0xFFFF on consecutive cycles.
  - After the 4th write: full=1, count=4.
  - Then rd for 4 cycles → data_out 0x0005, 0x0003, 0x7FFF, 0xFFFF, each with data_valid=1 one cycle after rd.
  - Ends with empty=1.
- Overflow: with full, wr=1 and data_in=0x1234, rd=0 → overflow=1, count stays 4. A subsequent drain never shows 0x1234.
- Underflow and empty simultaneous access:
  - rd on empty → underflow=1, data_valid=0, data_out unchanged.
  - Then wr=1 and rd=1 together with data_in=0x00AA on empty → count=1, data_valid=0.
  - Next rd → data_out=0x00AA.
- Full with simultaneous rd/wr, wrap-around:
  - Preload 0x0001..0x0004 (full), then 6 cycles of wr=rd=1 with data_in 0x0010..0x0015.
  - Outputs are 0x0001..0x0004, then 0x0010, 0x0011; full stays 1 and count stays 4 throughout.
  - Pointers wrap without loss.
- Reset mid-operation: with count=3, pulse reset_n low asynchronously (between edges) → count=0, empty=1 immediately.
  - The next rd raises underflow.
  - Old data is never emitted.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN (Kahn Process Network) datapath.
//   KPN_DATA_WIDTH    : token width in bits, matching the subtractor operands.
//   kpn_token_t       : one token on a KPN edge.
//   KPN_DEFAULT_DEPTH : default number of token slots per FIFO edge.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH    = 16;
  localparam int KPN_DEFAULT_DEPTH = 8;

  typedef logic [KPN_DATA_WIDTH-1:0] kpn_token_t;

endpackage : kpn_pkg

// File: rtl/fifo_storage_ram.sv
// Token storage for one FIFO channel: DEPTH x DATA_WIDTH register array with
// one synchronous write port and one synchronous read port.
// Ports:
//   clk      : system clock
//   reset_n  : async active-low reset (read-data register only)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata updates on the next edge
//   i_raddr  : read address
//   o_rdata  : registered read data, holds when i_re is low
module fifo_storage_ram
  import kpn_pkg::*;
#(
  parameter  int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter  int DEPTH      = KPN_DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset on purpose; validity is tracked by the
  // pointers and count, and a reset-free array maps onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // When full, a simultaneous read and write hit the same slot; the read
  // samples the old contents, so the oldest token is returned as required.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : fifo_storage_ram

// File: rtl/fifo_channel_module.sv
// Bounded FIFO channel implementing one KPN edge, feeding subtractor_module.
// Blocking-write / blocking-read semantics are exposed as full / empty.
// Ports:
//   clk        : system clock, all state updates on posedge
//   reset_n    : async active-low reset, discards all tokens
//   wr         : producer write strobe
//   data_in    : token written when wr is accepted
//   rd         : consumer read strobe
//   data_out   : registered token from the last accepted read
//   data_valid : high for exactly the cycle after an accepted read
//   full       : occupancy == DEPTH
//   empty      : occupancy == 0
//   count      : current occupancy, 0..DEPTH
//   overflow   : sticky, set by a rejected write
//   underflow  : sticky, set by a rejected read
module fifo_channel_module
  import kpn_pkg::*;
#(
  parameter  int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter  int DEPTH      = KPN_DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the registered count rather than comparing pointers, so
  // they are glitch-free and need no extra wrap bit.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle. A read on empty is never accepted (no fall-through).
  assign w_rd_acc = rd && !w_empty;
  assign w_wr_acc = wr && (!w_full || w_rd_acc);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register sees the pre-edge values of w_wr_acc / w_rd_acc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      r_data_valid <= w_rd_acc;
      if (wr && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_storage_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

  assign data_valid = r_data_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule : fifo_channel_module

// File: tb/tb_fifo_channel_module.sv
// Directed testbench for fifo_channel_module with DEPTH=4: a vector table for
// fill/drain/overflow/underflow, then hand-written wrap and mid-reset cases.
module tb_fifo_channel_module;
  import kpn_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr;
  kpn_token_t    data_in;
  logic          rd;
  kpn_token_t    data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_channel_module #(
    .DATA_WIDTH (KPN_DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .data_in    (data_in),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;
    logic        dv;
    logic [15:0] dout;
    logic        ovf;
    logic        unf;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge happen, sample 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    @(negedge clk);
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] c, input logic f,
                             input logic e, input logic o, input logic u);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " flags{full,empty,ovf,unf}"}, 32'({full, empty, overflow, underflow}),
          32'({f, e, o, u}));
  endtask

  initial begin
    wr      = 1'b0;
    rd      = 1'b0;
    data_in = '0;
    reset_n = 1'b0;

    //            wr    rd    din       cnt   full  empty dv    dout      ovf   unf
    vecs[0]  = '{1'b1, 1'b0, 16'h0005, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0003, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h7FFF, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 16'h00AA, 3'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b1, 1'b1};

    // Reset held low for two cycles, released between edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset data_valid", 32'(data_valid), 32'h0);

    // Fill, overflow, drain, underflow, simultaneous access on empty.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                  vecs[i].ovf, vecs[i].unf);
      check($sformatf("vec%0d data_valid", i), 32'(data_valid), 32'(vecs[i].dv));
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
    end

    // Full with simultaneous read/write: pointers wrap, order preserved.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 16'(i));
    end
    check("preload count", 32'(count), 32'd4);
    check("preload full", 32'(full), 32'd1);
    begin
      logic [15:0] exp_out [6];
      exp_out = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0010, 16'h0011};
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 1'b1, 16'h0010 + 16'(i));
        check($sformatf("wrap%0d data_out", i), 32'(data_out), 32'(exp_out[i]));
        check($sformatf("wrap%0d data_valid", i), 32'(data_valid), 32'd1);
        check($sformatf("wrap%0d count", i), 32'(count), 32'd4);
        check($sformatf("wrap%0d full", i), 32'(full), 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      check($sformatf("wrapdrain%0d data_out", i), 32'(data_out), 32'(16'h0012 + 16'(i)));
      check($sformatf("wrapdrain%0d data_valid", i), 32'(data_valid), 32'd1);
    end
    check("wrapdrain empty", 32'(empty), 32'd1);

    // Reset mid-operation with three tokens stored.
    step(1'b1, 1'b0, 16'h0BAD);
    step(1'b1, 1'b0, 16'h0BEE);
    step(1'b1, 1'b0, 16'h0CAB);
    step(1'b0, 1'b0, 16'h0000);
    check("pre-reset count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("async reset data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 16'h0000);
    check_state("post-reset rd", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("post-reset data_valid", 32'(data_valid), 32'd0);
    check("post-reset data_out", 32'(data_out), 32'h0);
    step(1'b0, 1'b1, 16'h0000);
    check("post-reset 2nd rd data_valid", 32'(data_valid), 32'd0);
    check("post-reset 2nd rd data_out", 32'(data_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_channel_module
